// File: rtl/br_resolve_unit_pkg.sv
// br_resolve_unit_pkg: shared widths, branch-task enum and resolution buffer types
package br_resolve_unit_pkg;

    // Global machine configuration: branch-stack depth (one-hot b_id width),
    // resolutions accepted per cycle, and PC width.
    localparam int DEPTH = 4;
    localparam int N     = 2;
    localparam int XLEN  = 32;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } BR_TASK;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } BR_RES_STATE;

    typedef struct packed {
        logic             valid;
        logic [DEPTH-1:0] b_id;
        logic [DEPTH-1:0] b_mask;
        logic             mispred;
        logic [XLEN-1:0]  target;
    } BR_RES_PACKET;

    typedef BR_RES_PACKET BR_RES_ENTRY;

    // Saturating 32-bit increment for event counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/br_resolve_unit_psel_gen.sv
// br_resolve_unit_psel_gen: lowest-index priority selector granting up to REQS set bits
module br_resolve_unit_psel_gen #(
    parameter int WIDTH = 4,
    parameter int REQS  = 1
) (
    input  logic [WIDTH-1:0]            req,
    output logic [REQS-1:0][WIDTH-1:0]  gnt_bus,
    output logic                        empty
);

    logic [WIDTH-1:0] rem;

    // Peel off the lowest remaining request bit once per grant slot.
    always_comb begin
        rem = req;
        for (int r = 0; r < REQS; r++) begin
            gnt_bus[r] = rem & (~rem + WIDTH'(1));
            rem        = rem & ~gnt_bus[r];
        end
    end

    assign empty = ~|req;

endmodule

// File: rtl/br_resolve_unit.sv
// br_resolve_unit: buffers resolved branches and issues one CLEAR/SQUASH per cycle to the branch stack
// Optional: define BR_RESOLVE_STATS_EN for stat_resolved/stat_squashes counters (plus DEBUG issue trace).
module br_resolve_unit
    import br_resolve_unit_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N-1:0]              res_valid,
    input  logic [N-1:0][DEPTH-1:0]   res_b_id,
    input  logic [N-1:0][DEPTH-1:0]   res_b_mask,
    input  logic [N-1:0]              res_mispred,
    input  logic [N-1:0][XLEN-1:0]    res_target,
    output BR_TASK                    br_task,
    output logic [DEPTH-1:0]          rem_b_id,
    output logic                      redirect_valid,
    output logic [XLEN-1:0]           redirect_pc,
    output logic                      stall_dispatch,
    output logic                      overflow
`ifdef BR_RESOLVE_STATS_EN
    ,
    output logic [31:0]               stat_resolved,
    output logic [31:0]               stat_squashes
`endif
);

    BR_RES_ENTRY [DEPTH-1:0]      entries, entries_d;
    BR_RES_STATE                  state;
    logic [DEPTH-1:0]             last_sq_id;
    logic [DEPTH-1:0]             ent_valid, mp_valid, mp_ids;
    logic [DEPTH-1:0]             sq_sel, iss_sel, iss_id, live_ids;
    logic                         sq_found, is_sq, is_clr;
    logic [XLEN-1:0]              iss_target;
    logic [0:0][DEPTH-1:0]        clr_gnt;
    logic                         clr_empty;
    logic [DEPTH-1:0]             kill_id, clr_id;
    logic [N-1:0]                 arr_keep, alloc_none;
    logic [N-1:0][DEPTH-1:0]      free;
    logic [N-1:0][0:0][DEPTH-1:0] alloc;
    logic                         ovf_set;

    // Oldest mispredict: a mispredicted entry none of whose ancestors is also mispredicted.
    always_comb begin
        mp_ids   = '0;
        sq_sel   = '0;
        sq_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = entries[i].valid;
            mp_valid[i]  = entries[i].valid && entries[i].mispred;
            mp_ids       = mp_ids | (mp_valid[i] ? entries[i].b_id : '0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!sq_found && mp_valid[i] && (entries[i].b_mask & ~entries[i].b_id & mp_ids) == '0) begin
                sq_sel[i] = 1'b1;
                sq_found  = 1'b1;
            end
        end
    end

    br_resolve_unit_psel_gen #(.WIDTH(DEPTH), .REQS(1)) u_clr_sel (
        .req     (ent_valid),
        .gnt_bus (clr_gnt),
        .empty   (clr_empty)
    );

    // Pick this cycle's issue: squash wins, otherwise clear the lowest valid slot; nothing in RECOVER.
    always_comb begin
        is_sq      = state == IDLE && sq_found;
        is_clr     = state == IDLE && !sq_found && !clr_empty;
        iss_sel    = is_sq ? sq_sel : is_clr ? clr_gnt[0] : '0;
        iss_id     = '0;
        iss_target = '0;
        live_ids   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            iss_id     = iss_id | (iss_sel[i] ? entries[i].b_id : '0);
            iss_target = iss_target | (iss_sel[i] ? entries[i].target : '0);
            live_ids   = live_ids | (entries[i].valid && !iss_sel[i] ? entries[i].b_id : '0);
        end
    end

    assign br_task        = is_sq ? SQUASH : is_clr ? CLEAR : NOTHING;
    assign rem_b_id       = iss_id;
    assign redirect_valid = is_sq;
    assign redirect_pc    = is_sq ? iss_target : '0;
    assign stall_dispatch = state == RECOVER;

    // Arrivals on the wrong path of a squash (this cycle or the one being recovered) are dropped.
    assign kill_id = is_sq ? iss_id : state == RECOVER ? last_sq_id : '0;
    assign clr_id  = is_clr ? iss_id : '0;

    // Slots are taken lowest-first in input order from those free before this edge,
    // so a slot freed by this cycle's issue is not reused until next cycle.
    for (genvar k = 0; k < N; k++) begin : g_alloc
        assign arr_keep[k] = res_valid[k] && (res_b_mask[k] & kill_id) == '0;
        if (k == 0) begin : g_first
            assign free[k] = ~ent_valid;
        end else begin : g_next
            assign free[k] = free[k-1] & ~(arr_keep[k-1] ? alloc[k-1][0] : '0);
        end
        br_resolve_unit_psel_gen #(.WIDTH(DEPTH), .REQS(1)) u_alloc (
            .req     (free[k]),
            .gnt_bus (alloc[k]),
            .empty   (alloc_none[k])
        );
    end

    // Next buffer contents: free issued/squashed entries, strip cleared id, then store arrivals.
    always_comb begin
        entries_d = entries;
        ovf_set   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_sel[i] || (is_sq && (entries[i].b_mask & iss_id) != '0))
                entries_d[i].valid = 1'b0;
            entries_d[i].b_mask = entries[i].b_mask & ~clr_id;
        end
        for (int k = 0; k < N; k++) begin
            if (arr_keep[k]) begin
                ovf_set = ovf_set | alloc_none[k];
                for (int i = 0; i < DEPTH; i++) begin
                    if (alloc[k][0][i])
                        entries_d[i] = '{valid: 1'b1, b_id: res_b_id[k], b_mask: res_b_mask[k] & ~clr_id,
                                         mispred: res_mispred[k], target: res_target[k]};
                end
            end
        end
    end

    // Resolution buffer storage; reset discards every entry.
    always_ff @(posedge clock) begin
        entries <= reset ? '0 : entries_d;
    end

    // Recovery FSM: one RECOVER cycle after each squash, plus sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_sq_id <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= is_sq ? RECOVER : IDLE;
            last_sq_id <= is_sq ? iss_id : '0;
            overflow   <= overflow | ovf_set;
        end
    end

    // An arriving b_id must not already be live in the buffer (the entry issued this cycle is leaving).
    always_ff @(posedge clock) begin
        for (int k = 0; k < N; k++) begin
            if (!reset && res_valid[k])
                assert ((res_b_id[k] & live_ids) == '0)
                else $error("br_resolve_unit: arriving b_id %b already buffered", res_b_id[k]);
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    // Saturating counts of issued resolutions and of squashes.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_resolved <= '0;
            stat_squashes <= '0;
        end else begin
            if (is_sq || is_clr)
                stat_resolved <= sat_inc(stat_resolved);
            if (is_sq)
                stat_squashes <= sat_inc(stat_squashes);
        end
    end
`ifdef DEBUG
    // Trace every issued resolution.
    always_ff @(posedge clock) begin
        if (!reset && (is_sq || is_clr))
            $display("br_resolve_unit: %s b_id=%b pc=%h", is_sq ? "SQUASH" : "CLEAR", iss_id, iss_target);
    end
`endif
`endif

endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
- Producer end of the branch-stack control interface. Drives br_task (NOTHING/CLEAR/SQUASH), rem_b_id and the fetch redirect.
- Collects up to N resolved branches per cycle from the branch FUs and buffers them. Each cycle it emits at most one CLEAR or SQUASH, with squash priority to the oldest mispredict.
- Sits between the complete stage and the branch stack / fetch / ROB recovery logic.

Parameters:
- DEPTH, `BRANCH_PRED_SZ: b_id/b_mask width, one-hot b_ids; also the buffer entry count.
- N, `N: branch resolutions accepted per cycle.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- res_valid  in  [N]  resolution i valid
- res_b_id  in  [N][DEPTH]  one-hot b_id of resolved branch
- res_b_mask  in  [N][DEPTH]  b_mask at dispatch (includes own b_id)
- res_mispred  in  [N]  1 if actual direction/target != prediction
- res_target  in  [N][`XLEN]  correct next PC
- br_task  out  BR_TASK  NOTHING/CLEAR/SQUASH to branch stack, ROB, RS
- rem_b_id  out  [DEPTH]  one-hot b_id being cleared/squashed; '0 when NOTHING
- redirect_valid  out  1  high only in a SQUASH cycle
- redirect_pc  out  [`XLEN]  res_target of the squashed branch; '0 otherwise
- stall_dispatch  out  1  high during RECOVER
- overflow  out  1  sticky error, buffer had no free slot for an arrival

Behaviour:
- Buffer: DEPTH entries {valid, b_id, b_mask, mispred, target}.
  - Allocation: lowest-index free slot, in input order 0..N-1.
  - Live branches never exceed DEPTH, so there is no backpressure.
- Issue is combinational from registered buffer contents. An arrival at edge t is issuable in cycle t+1; minimum latency is 1 cycle.
- Issue select, with M = set of valid mispredicted entries:
  - If M is non-empty: pick entry e in M with (e.b_mask & ~e.b_id) & OR(M.b_id) == 0, i.e. the oldest. Ties go to the lowest index. br_task=SQUASH, rem_b_id=e.b_id, redirect_valid=1, redirect_pc=e.target.
  - Else if any valid entry exists: lowest-index entry, br_task=CLEAR, rem_b_id=its b_id.
  - Else br_task=NOTHING.
- Buffer update on SQUASH of id S:
  - Issued entry is freed.
  - Every buffered entry with b_mask & S is freed (younger, wrong path).
  - Same-cycle arrivals with b_mask & S are dropped, not stored.
- Buffer update on CLEAR of id C:
  - Issued entry is freed.
  - All remaining entries and same-cycle arrivals get b_mask &= ~C.
- FSM:
  - IDLE: issuing SQUASH -> RECOVER, and latch last_sq_id=S.
  - RECOVER: exactly one cycle. br_task=NOTHING, stall_dispatch=1. Arrivals with b_mask & last_sq_id are dropped; others are stored. Then -> IDLE, last_sq_id='0.
- Reset values:
  - State IDLE, buffer all invalid, last_sq_id='0.
  - Outputs: br_task=NOTHING, rem_b_id='0, redirect_valid=0, redirect_pc='0, stall_dispatch=0, overflow=0.
  - Reset mid-RECOVER or with a full buffer discards everything.
- Boundaries:
  - Arrival of a b_id already buffered: undefined input; simulation assertion.
  - N arrivals with only k<N free slots: first k stored, overflow set sticky until reset.
  - Buffer exactly full plus a same-cycle issue: the issued slot is not reusable in the same cycle.

Optional Feature:
- BR_RESOLVE_STATS_EN
  - Defined: adds 32-bit saturating output counters stat_resolved (CLEARs+SQUASHes issued) and stat_squashes, reset to 0, plus $display of each issue under DEBUG.
  - Undefined: ports and logic absent.

Decomposition:
- sys_defs.svh: BR_TASK enum (existing), BR_RES_PACKET {valid, b_id, b_mask, mispred, target}, BR_RES_ENTRY typedef.
- Sub-module: psel_gen (REQS=1) for free-slot allocation and lowest-index CLEAR select.
- Oldest-mispredict select: inline loop.

Test Plan:
- DEPTH=4,N=2. Single b_id 0001, mispred=0 at t0 -> t1: CLEAR, rem_b_id=0001; t2: NOTHING, buffer empty.
- b_id 0001 mask 0001 and b_id 0010 mask 0011, both mispred, same cycle -> SQUASH 0001, redirect_pc=target0, entry 0010 freed; next cycle RECOVER with stall_dispatch=1, br_task=NOTHING.
- Arrival with mask 0101 in the same cycle as SQUASH 0100 -> dropped. Arrival with mask 0011 during RECOVER after squash 0001 -> dropped. Arrival with mask 1000 -> stored.
- Buffered correct 0010 mask 0011 and correct 0001 mask 0001 -> CLEAR 0001 then CLEAR 0010; second entry's mask observed as 0010 after the first clear.
- 4 entries filled, then a 5th arrival -> overflow=1 and stays 1; synchronous reset -> all outputs return to reset values next cycle.
- With BR_RESOLVE_STATS_EN: 3 clears + 1 squash -> stat_resolved=4, stat_squashes=1.
